// File: rtl/alu_seq_core.sv
// Clocked signed W-bit calculator: add/sub/abs in one cycle, shift-add multiply in W+1 cycles,
// accumulate into the result register, optional saturation and a sticky overflow flag.
module alu_seq_core #(
    parameter int W        = 4,
    parameter int SATURATE = 0
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         clr_sticky,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         ovf_sticky
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic [1:0]     state;
    logic [3:0]     op_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [2*W-1:0] mcand;
    logic [2*W-1:0] prod;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    logic [W-1:0]   raw;
    logic           raw_ovf;
    logic           raw_neg;
    logic [W-1:0]   exec_val;
    logic           mneg;
    logic [2*W-1:0] sprod;
    logic [W:0]     hi;
    logic           movf;
    logic [W-1:0]   mul_val;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? -v : v;
    endfunction

    assign busy = (state != IDLE);

    // raw_neg is the sign of the mathematically true result, used to pick the clamp direction
    always_comb begin
        raw     = result;
        raw_ovf = 1'b0;
        raw_neg = 1'b0;
        case (op_r)
            4'b0000, 4'b0100: begin
                raw     = a_r + b_r;
                raw_ovf = (a_r[W-1] == b_r[W-1]) && (raw[W-1] != a_r[W-1]);
                raw_neg = a_r[W-1];
            end
            4'b0001: begin
                raw     = a_r - b_r;
                raw_ovf = (a_r[W-1] != b_r[W-1]) && (raw[W-1] != a_r[W-1]);
                raw_neg = a_r[W-1];
            end
            4'b0101: begin
                raw     = b_r - a_r;
                raw_ovf = (a_r[W-1] != b_r[W-1]) && (raw[W-1] != b_r[W-1]);
                raw_neg = b_r[W-1];
            end
            4'b0010, 4'b0011: begin
                raw     = mag(b_r);
                raw_ovf = (b_r == MIN_VAL);
            end
            4'b0110, 4'b0111: begin
                raw     = mag(a_r);
                raw_ovf = (a_r == MIN_VAL);
            end
            4'b1001: begin
                raw     = result + a_r;
                raw_ovf = (result[W-1] == a_r[W-1]) && (raw[W-1] != a_r[W-1]);
                raw_neg = a_r[W-1];
            end
            default: begin
                raw     = result;
                raw_ovf = 1'b0;
                raw_neg = 1'b0;
            end
        endcase
    end

    assign exec_val = ((SATURATE != 0) && raw_ovf) ? (raw_neg ? MIN_VAL : MAX_VAL) : raw;

    // The product fits in W bits only if its top W+1 bits are all copies of the sign
    assign mneg    = a_r[W-1] ^ b_r[W-1];
    assign sprod   = mneg ? -prod : prod;
    assign hi      = sprod[2*W-1:W-1];
    assign movf    = !((&hi) || !(|hi));
    assign mul_val = ((SATURATE != 0) && movf) ? (sprod[2*W-1] ? MIN_VAL : MAX_VAL)
                                               : sprod[W-1:0];

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state      <= IDLE;
            done       <= 1'b0;
            result     <= '0;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            prod       <= '0;
        end else begin
            done <= 1'b0;
            if (clr_sticky) ovf_sticky <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r <= op;
                        a_r  <= a;
                        b_r  <= b;
                        if (op == 4'b1000) begin
                            state  <= MUL;
                            cnt    <= '0;
                            mcand  <= {{W{1'b0}}, mag(a)};
                            mplier <= mag(b);
                            prod   <= '0;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    result <= exec_val;
                    ovf    <= raw_ovf;
                    done   <= 1'b1;
                    if (raw_ovf) ovf_sticky <= 1'b1;
                    state  <= IDLE;
                end
                MUL: begin
                    if (cnt == CW'(W)) begin
                        result <= mul_val;
                        ovf    <= movf;
                        done   <= 1'b1;
                        if (movf) ovf_sticky <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        if (mplier[0]) prod <= prod + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core: wrap (SATURATE=0) and clamp (SATURATE=1) instances share stimulus.
module tb_alu_seq_core;

    typedef struct {
        logic [3:0] res;
        logic       ovf;
        logic       st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] op = 4'd0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       clr = 1'b0;

    logic       busy0, done0, ovf0, st0;
    logic [3:0] res0;
    logic       busy1, done1, ovf1, st1;
    logic [3:0] res1;

    exp_t q0[$];
    exp_t q1[$];
    bit   model_st0 = 1'b0;
    bit   model_st1 = 1'b0;
    int   errors = 0;
    int   checks = 0;

    alu_seq_core #(.W(4), .SATURATE(0)) dut_wrap (
        .CLOCK_50(clk), .RESET_N(rst_n), .start(start), .op(op), .a(a), .b(b),
        .clr_sticky(clr), .busy(busy0), .done(done0), .result(res0), .ovf(ovf0),
        .ovf_sticky(st0)
    );

    alu_seq_core #(.W(4), .SATURATE(1)) dut_sat (
        .CLOCK_50(clk), .RESET_N(rst_n), .start(start), .op(op), .a(a), .b(b),
        .clr_sticky(clr), .busy(busy1), .done(done1), .result(res1), .ovf(ovf1),
        .ovf_sticky(st1)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitors pop the next expectation whenever an instance pulses done
    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) begin
                check_output("wrap_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check_output("wrap_result", int'($signed(res0)), int'($signed(e.res)));
                check_output("wrap_ovf", int'(ovf0), int'(e.ovf));
                check_output("wrap_sticky", int'(st0), int'(e.st));
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                check_output("sat_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check_output("sat_result", int'($signed(res1)), int'($signed(e.res)));
                check_output("sat_ovf", int'(ovf1), int'(e.ovf));
                check_output("sat_sticky", int'(st1), int'(e.st));
            end
        end
    end

    // Issue one operation and wait for its done; optionally hold clr_sticky or poke start while busy
    task automatic apply_stimulus(input logic [3:0] o, input int av, input int bv,
                                  input int r0, input int v0, input int r1, input int v1,
                                  input bit do_clr, input bit poke);
        exp_t e;
        int lat;
        int want_lat;
        model_st0 = (v0 != 0) || (!do_clr && model_st0);
        model_st1 = (v1 != 0) || (!do_clr && model_st1);
        e.res = 4'(r0); e.ovf = (v0 != 0); e.st = model_st0; q0.push_back(e);
        e.res = 4'(r1); e.ovf = (v1 != 0); e.st = model_st1; q1.push_back(e);
        want_lat = (o == 4'b1000) ? 5 : 1;
        @(negedge clk);
        start = 1'b1; op = o; a = 4'(av); b = 4'(bv); clr = do_clr;
        @(posedge clk);
        #1 start = 1'b0;
        check_output("busy_after_start", int'(busy0 & busy1), 1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (poke && lat == 2) begin
                start = 1'b1; op = 4'b0000; a = 4'd7; b = 4'd7;
            end else if (poke && lat == 3) begin
                start = 1'b0;
            end
        end while (!done0 && lat < 20);
        start = 1'b0;
        clr = 1'b0;
        check_output("done_latency", lat, want_lat);
        check_output("done_both", int'(done1), 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_state", int'({busy0, done0, res0, ovf0, st0, busy1, done1, res1, ovf1, st1}), 0);
        rst_n = 1'b1;

        //             op       a   b   wrap res/ovf  sat res/ovf  clr poke
        apply_stimulus(4'b0000,  7,  1,  -8, 1,  7, 1, 0, 0);
        apply_stimulus(4'b0101, -7,  7,  -2, 1,  7, 1, 0, 0);
        apply_stimulus(4'b0001, -7, -7,   0, 0,  0, 0, 0, 0);
        apply_stimulus(4'b0011,  0, -8,  -8, 1,  7, 1, 0, 0);
        apply_stimulus(4'b0110, -3,  0,   3, 0,  3, 0, 0, 0);
        apply_stimulus(4'b1001,  2,  0,   5, 0,  5, 0, 0, 0);
        apply_stimulus(4'b1001,  2,  0,   7, 0,  7, 0, 0, 0);
        apply_stimulus(4'b1001,  1,  0,  -8, 1,  7, 1, 1, 0);
        apply_stimulus(4'b1000,  3, -2,  -6, 0, -6, 0, 0, 1);
        apply_stimulus(4'b1000,  4,  4,   0, 1,  7, 1, 0, 0);
        apply_stimulus(4'b1010,  5,  5,   0, 0,  7, 0, 0, 0);
        apply_stimulus(4'b0000,  2,  3,   5, 0,  5, 0, 1, 0);
        apply_stimulus(4'b1000, -8, -8,   0, 1,  7, 1, 0, 0);
        apply_stimulus(4'b1000, -3,  3,   7, 1, -8, 1, 0, 0);
        apply_stimulus(4'b0111, -8,  0,  -8, 1,  7, 1, 0, 0);
        apply_stimulus(4'b0001, -8,  1,   7, 1, -8, 1, 0, 0);
        apply_stimulus(4'b0100, -1, -2,  -3, 0, -3, 0, 0, 0);

        // Abort a multiply with reset two edges after acceptance
        @(negedge clk);
        start = 1'b1; op = 4'b1000; a = 4'd3; b = 4'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("abort_outputs", int'({busy0, done0, res0, ovf0, st0, busy1, done1, res1, ovf1, st1}), 0);
        rst_n = 1'b1;
        model_st0 = 1'b0;
        model_st1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_output("abort_no_done", int'(done0 | done1), 0);

        apply_stimulus(4'b0000,  1,  2,   3, 0,  3, 0, 0, 0);

        repeat (3) @(posedge clk);
        check_output("queue_drained", q0.size() + q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, clocked successor to the 4-bit combinational signed calculator.
- Registers operands on a start handshake and executes the existing add, subtract and absolute-value ops on W-bit two's-complement operands.
- Adds a multi-cycle shift-add multiply, an accumulate op, optional saturation and a sticky overflow flag.
- Sits between the switch/key input logic and the seven-segment display converters.

Parameters:
W, 4, operand/result width in bits (two's complement, W>=2)
SATURATE, 0, 0 = wrap on overflow; 1 = clamp result to +max/-min on overflow

Ports:
CLOCK_50  input  1  system clock, all state updates on rising edge
RESET_N  input  1  reset, synchronous, active-low
start  input  1  request; sampled only when busy=0
op  input  4  operation select, latched with start
a  input  W  operand A, signed, latched with start
b  input  W  operand B, signed, latched with start
clr_sticky  input  1  clears ovf_sticky
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when result/ovf update
result  output  W  signed result register
ovf  output  1  overflow of the most recent operation
ovf_sticky  output  1  OR of all ovf since reset/clear

Behaviour:
- Reset: RESET_N=0 at a rising edge forces state=IDLE, busy=0, done=0, result=0, ovf=0, ovf_sticky=0, mul counter=0.
- Reset mid-operation aborts the operation with no done pulse.
- Op encoding:
  - 0000/0100: A+B
  - 0001: A-B
  - 0101: B-A
  - 0010/0011: |B|
  - 0110/0111: |A|
  - 1000: MUL A*B
  - 1001: ACC, result+A, using the current result register
  - 1010-1111: reserved; done pulses, result held, ovf=0.
- States: IDLE, EXEC, MUL.
  - IDLE: on an edge with start=1, latch a, b, op; go to MUL if op=1000, else EXEC.
  - busy=1 from the edge after start acceptance until the done edge.
  - start while busy=1 is ignored; its operands are not latched.
- EXEC: one edge. result and ovf are written, done=1 for exactly one cycle, state returns to IDLE.
  - Latency: start sampled at edge N, done/result valid after edge N+1.
- MUL: sequential shift-add on operand magnitudes, one partial-product step per edge, W steps.
  - Sign applied at the end; result/ovf/done after edge N+W+1 (W=4: edge N+5).
  - ovf=1 if the full 2W-bit signed product is outside [-2^(W-1), 2^(W-1)-1].
  - Wrap mode: result = low W bits of the product.
- Overflow rules:
  - add/acc: operand signs equal and result sign differs.
  - sub: operand signs differ and result sign differs from the minuend.
  - abs: operand = -2^(W-1).
- Saturate mode:
  - SATURATE=0: result is the wrapped value; abs(min) returns min.
  - SATURATE=1 and ovf=1: result = 2^(W-1)-1 if the true value is positive, else -2^(W-1); abs(min) returns max.
- done may re-assert at the earliest one cycle after IDLE re-entry: back-to-back start is accepted on the edge when state is IDLE.
- ovf_sticky:
  - Set on any done with ovf=1.
  - clr_sticky clears it.
  - If set and clear occur on the same edge, set wins.
- ovf and result hold their values between operations; done is 0 outside pulse cycles.

Test Plan:
- W=4, SATURATE=0: start op=0000 a=7 b=1 -> after edge N+1 done=1, result=-8 (1000), ovf=1, ovf_sticky=1. Repeat with SATURATE=1 -> result=7, ovf=1.
- op=0101 a=-7 b=7 -> result=-2 (B-A=14 wraps), ovf=1. op=0001 a=-7 b=-7 -> result=0, ovf=0.
- op=0011 b=-8 -> ovf=1, result=-8 (SATURATE=0) / 7 (SATURATE=1). op=0110 a=-3 -> result=3, ovf=0.
- op=1000 a=3 b=-2 -> busy=1 for 5 cycles, done after edge N+5, result=-6, ovf=0. a=4 b=4 -> result=0 (wrap), ovf=1. A second start during busy is ignored and result is unaffected.
- ACC after result=3: op=1001 a=2 -> result=5. Repeat -> 7, then a=1 -> -8, ovf=1. clr_sticky with a concurrent ovf done -> ovf_sticky stays 1.
- RESET_N=0 at edge N+2 of a MUL -> all outputs 0, no done pulse. The next start after release completes normally.
